// File: rtl/run_controller.sv
// Run/halt sequencer: gates the core clock-enable, counts enabled cycles, drains after halt, flags budget timeout.
// Latency: start -> cpuEn next cycle; halt -> done DRAIN_CYCLES+1 cycles later. No backpressure; start ignored while busy.
module run_controller #(
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 2000,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isHalt,
    input  logic             stepMode,
    input  logic             stepReq,
    output logic             cpuEn,
    output logic             busy,
    output logic             done,
    output logic             timedOut,
    output logic [CNT_W-1:0] cycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_T      = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MAX_LAST   = MAX_T - CNT_W'(1);
    localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [31:0]      r_drain, w_drain_nxt;

    assign cpuEn      = (r_state == S_RUN) && (!stepMode || stepReq);
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign timedOut   = (r_state == S_TIMEOUT);
    assign cycleCount = r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_drain_nxt = r_drain;
        case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = '0;
                end
            end
            S_RUN: begin
                // Saturation only matters for the unlimited build; a budget stops the count first.
                if (cpuEn && (r_count != '1)) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                if (isHalt) begin
                    w_drain_nxt = '0;
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if ((MAX_CYCLES != 0) && cpuEn && (r_count == MAX_LAST)) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                w_drain_nxt = r_drain + 32'd1;
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_drain <= w_drain_nxt;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a default build (budget 2000, drain 4) checked through an end-of-run scoreboard,
// plus a narrow unlimited build with no drain checked directly.
module tb_run_controller;

    typedef struct {
        logic        exp_done;
        logic        exp_to;
        logic [31:0] exp_cnt;
        int          exp_busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        isHalt = 1'b0;
    logic        stepMode = 1'b0;
    logic        stepReq = 1'b0;
    logic        cpuEn, busy, done, timedOut;
    logic [31:0] cycleCount;

    logic        start1 = 1'b0;
    logic        isHalt1 = 1'b0;
    logic        cpuEn1, busy1, done1, timedOut1;
    logic [3:0]  cycleCount1;

    int   total = 0;
    int   bad = 0;
    exp_t q0[$];

    always #5 clk = ~clk;

    run_controller u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .isHalt     (isHalt),
        .stepMode   (stepMode),
        .stepReq    (stepReq),
        .cpuEn      (cpuEn),
        .busy       (busy),
        .done       (done),
        .timedOut   (timedOut),
        .cycleCount (cycleCount)
    );

    run_controller #(
        .CNT_W        (4),
        .MAX_CYCLES   (0),
        .DRAIN_CYCLES (0)
    ) u_dut_nodrain (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .isHalt     (isHalt1),
        .stepMode   (1'b0),
        .stepReq    (1'b0),
        .cpuEn      (cpuEn1),
        .busy       (busy1),
        .done       (done1),
        .timedOut   (timedOut1),
        .cycleCount (cycleCount1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        int i;
        i = 0;
        while (!(done || timedOut) && (i < limit)) begin
            tick();
            i++;
        end
        chk(name, {31'd0, (done || timedOut)}, 32'd1);
    endtask

    // Monitor: counts busy cycles of each run and checks the run summary when it ends.
    int   mon_busy = 0;
    logic mon_prev_end = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_busy     = 0;
            mon_prev_end = 1'b0;
        end else begin
            if (busy) mon_busy++;
            if ((done || timedOut) && !mon_prev_end) begin
                if (q0.size() == 0) begin
                    chk("unexpected_run_end", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("end_done", {31'd0, done}, {31'd0, e.exp_done});
                    chk("end_timedOut", {31'd0, timedOut}, {31'd0, e.exp_to});
                    chk("end_cycleCount", cycleCount, e.exp_cnt);
                    chk("end_busy_cycles", mon_busy, e.exp_busy);
                end
                mon_busy = 0;
            end
            mon_prev_end = done || timedOut;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_timedOut", {31'd0, timedOut}, 32'd0);
        chk("rst_cycleCount", cycleCount, 32'd0);
        chk("rst_nodrain_cycleCount", {28'd0, cycleCount1}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Free run, halt in the 10th enabled cycle.
        q0.push_back('{1'b1, 1'b0, 32'd10, 14});
        do_start();
        chk("run1_cpuEn_after_start", {31'd0, cpuEn}, 32'd1);
        repeat (9) tick();
        isHalt = 1'b1;
        tick();
        isHalt = 1'b0;
        chk("run1_cpuEn_after_halt", {31'd0, cpuEn}, 32'd0);
        chk("run1_busy_in_drain", {31'd0, busy}, 32'd1);
        wait_end("run1_wait", 20);
        tick();

        // Restart from DONE, ignore a mid-run start, run into the budget.
        q0.push_back('{1'b0, 1'b1, 32'd2000, 2000});
        do_start();
        chk("run2_done_cleared", {31'd0, done}, 32'd0);
        chk("run2_count_cleared", cycleCount, 32'd0);
        repeat (99) tick();
        do_start();
        chk("run2_start_ignored_in_run", cycleCount, 32'd100);
        wait_end("run2_wait", 2100);
        chk("run2_cpuEn_after_timeout", {31'd0, cpuEn}, 32'd0);
        chk("run2_done_after_timeout", {31'd0, done}, 32'd0);
        tick();
        chk("run2_count_holds", cycleCount, 32'd2000);

        // Halt in the same cycle the budget would expire; start during drain is ignored.
        q0.push_back('{1'b1, 1'b0, 32'd2000, 2004});
        do_start();
        chk("run3_timedOut_cleared", {31'd0, timedOut}, 32'd0);
        repeat (1999) tick();
        chk("run3_count_before_halt", cycleCount, 32'd1999);
        isHalt = 1'b1;
        tick();
        isHalt = 1'b0;
        do_start();
        chk("run3_start_ignored_in_drain", cycleCount, 32'd2000);
        wait_end("run3_wait", 20);
        tick();

        // Single-step: three step requests five cycles apart, then halt.
        q0.push_back('{1'b1, 1'b0, 32'd3, 20});
        stepMode = 1'b1;
        do_start();
        chk("step_cpuEn_idle", {31'd0, cpuEn}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick();
            chk("step_cpuEn_idle_before_req", {31'd0, cpuEn}, 32'd0);
            stepReq = 1'b1;
            #1;
            chk("step_cpuEn_on_req", {31'd0, cpuEn}, 32'd1);
            tick();
            stepReq = 1'b0;
        end
        isHalt = 1'b1;
        #1;
        chk("step_cpuEn_on_halt_cycle", {31'd0, cpuEn}, 32'd0);
        tick();
        isHalt = 1'b0;
        wait_end("step_wait", 20);
        stepMode = 1'b0;
        tick();

        // Asynchronous reset mid-run, then a fresh run counts from zero.
        do_start();
        repeat (50) tick();
        chk("arst_count_before", cycleCount, 32'd50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cycleCount", cycleCount, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        q0.push_back('{1'b1, 1'b0, 32'd6, 10});
        do_start();
        chk("arst_restart_count", cycleCount, 32'd0);
        repeat (5) tick();
        chk("arst_restart_count5", cycleCount, 32'd5);
        isHalt = 1'b1;
        tick();
        isHalt = 1'b0;
        wait_end("arst_wait", 20);
        tick();
        chk("scoreboard_drained", q0.size(), 32'd0);

        // Unlimited budget, 4-bit counter, no drain.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (20) tick();
        chk("nd_saturate", {28'd0, cycleCount1}, 32'd15);
        chk("nd_no_timeout", {31'd0, timedOut1}, 32'd0);
        chk("nd_busy", {31'd0, busy1}, 32'd1);
        isHalt1 = 1'b1;
        tick();
        isHalt1 = 1'b0;
        chk("nd_done_next_cycle", {31'd0, done1}, 32'd1);
        chk("nd_busy_after_halt", {31'd0, busy1}, 32'd0);
        chk("nd_count_held", {28'd0, cycleCount1}, 32'd15);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("nd_restart_done_cleared", {31'd0, done1}, 32'd0);
        chk("nd_restart_count", {28'd0, cycleCount1}, 32'd0);
        repeat (2) tick();
        isHalt1 = 1'b1;
        tick();
        isHalt1 = 1'b0;
        chk("nd_run2_done", {31'd0, done1}, 32'd1);
        chk("nd_run2_count", {28'd0, cycleCount1}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Synthesizable run/halt sequencer for the core. Gates the core's clock-enable, counts executed cycles, and detects program halt. After a halt it drains for a fixed number of cycles so in-flight writes retire. It flags a timeout when a cycle budget is exhausted. It sits between the testbench/top-level start control and the core's enable and halt signals, replacing ad-hoc simulation watchdogs with a checkable hardware block.

Parameters:
CNT_W, 32, width of cycle counter
MAX_CYCLES, 2000, enabled-cycle budget before timeout; 0 = no limit
DRAIN_CYCLES, 4, idle cycles after halt before done; 0 allowed

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; honoured only in IDLE, DONE, TIMEOUT
isHalt  input  1  core halt indication, level
stepMode  input  1  1 = single-step, 0 = free run
stepReq  input  1  in stepMode, enables the core for this cycle
cpuEn  output  1  core clock-enable
busy  output  1  high in RUN or DRAIN
done  output  1  run ended by halt, sticky until next start
timedOut  output  1  run ended by budget, sticky until next start
cycleCount  output  CNT_W  enabled cycles in current/last run

Behaviour:
- Reset is asynchronous; it may assert at any time, including mid-run, and returns everything immediately to reset values.
  - Reset values: state IDLE, cpuEn=0, busy=0, done=0, timedOut=0, cycleCount=0, drain counter=0.
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT. All state and counter updates on posedge clk.
- cpuEn (combinational) = (state==RUN) & (~stepMode | stepReq). Zero in all other states.
- busy (combinational) = state is RUN or DRAIN.
- IDLE/DONE/TIMEOUT:
  - start=1 -> RUN next cycle.
  - cycleCount cleared to 0, done and timedOut cleared, on that same edge.
- RUN:
  - start is ignored.
  - cycleCount += 1 on every edge where cpuEn=1; no increment when cpuEn=0 (step mode idle).
  - isHalt is sampled every RUN cycle, whether or not cpuEn=1.
  - isHalt=1 -> DRAIN. cycleCount includes the halt cycle if cpuEn=1 in it.
  - Timeout when MAX_CYCLES!=0, cpuEn=1, cycleCount==MAX_CYCLES-1 and isHalt=0 -> TIMEOUT, with cycleCount becoming MAX_CYCLES.
  - Same-cycle halt and budget expiry: halt wins (DRAIN, not TIMEOUT).
  - MAX_CYCLES=0: cycleCount saturates at all-ones and never times out.
- DRAIN:
  - cpuEn=0, start ignored.
  - Drain counter loads 0 on entry and increments each cycle. The state exits to DONE on the edge where the counter reaches DRAIN_CYCLES-1.
  - DRAIN occupies exactly DRAIN_CYCLES cycles. DRAIN_CYCLES=0: RUN goes directly to DONE on the halt edge, skipping DRAIN.
  - isHalt is ignored in DRAIN.
- DONE: done=1. TIMEOUT: timedOut=1. Both hold, along with cycleCount, until the next start or reset.
- done and timedOut are never both 1.
- Latency:
  - start edge -> cpuEn high in the next cycle.
  - isHalt high in RUN -> cpuEn low next cycle; done high DRAIN_CYCLES+1 cycles after the halt cycle.
- cycleCount width is CNT_W. Comparison uses MAX_CYCLES truncated to CNT_W.

Test Plan:
- Reset then start=1 for 1 cycle, stepMode=0, isHalt rises after 10 enabled cycles -> cycleCount=10, busy for 10+4 cycles, done=1 on the 15th cycle after start accepted, timedOut=0.
- Free run, isHalt held 0, MAX_CYCLES=2000 -> timedOut=1 exactly after 2000 enabled cycles, cycleCount=2000, cpuEn low from then, done=0.
- isHalt rises in the same cycle cycleCount==1999 -> DRAIN then done=1, timedOut=0, cycleCount=2000.
- stepMode=1, stepReq pulsed 3 times spaced 5 cycles apart, then isHalt=1 -> cpuEn high only on the 3 stepReq cycles, cycleCount=3, done=1 after 4 drain cycles.
- rst_n dropped asynchronously mid-RUN (cycleCount=50) -> cpuEn, busy and cycleCount go to 0 without a clock edge. After release and start, counting restarts from 0.
- start asserted during RUN and DRAIN -> ignored (cycleCount not cleared). start in DONE -> new run, done cleared, cycleCount=0. DRAIN_CYCLES=0 build: done asserted on the cycle after isHalt.
